// File: rtl/dpwm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dpwm_pkg
// Purpose  : Shared defaults, FSM state type and helpers for the DPWM decoder.
// Revision : 1.0 - initial release
// ============================================================================
package dpwm_pkg;

    localparam int PERIOD_DEF = 10;
    localparam int REF_W_DEF  = 4;

    typedef enum logic [0:0] {
        WAIT = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dpwm_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dpwm_sync
// Purpose  : 2-flop synchronizer, optional 3-sample majority filter
//            (DPWM_DECODER_FILTER_EN) and rising-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module dpwm_sync
    import dpwm_pkg::*;
(
    input  logic f_in,
    input  logic Reset,
    input  logic signal_i,
    output logic synced_o,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic w_synced;

`ifdef DPWM_DECODER_FILTER_EN
    // Combinational vote over the last three synchronized samples: rejects
    // single-cycle glitches while adding exactly one cycle of delay.
    logic hist1_q, hist1_d;
    logic hist2_q, hist2_d;

    always_comb begin
        hist1_d = sync2_q;
        hist2_d = hist1_q;
    end

    always_ff @(posedge f_in or posedge Reset) begin
        if (Reset) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
        end
    end

    assign w_synced = maj3(sync2_q, hist1_q, hist2_q);
`else
    assign w_synced = sync2_q;
`endif

    always_comb begin
        sync1_d = signal_i;
        sync2_d = sync1_q;
        prev_d  = w_synced;
    end

    always_ff @(posedge f_in or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign synced_o = w_synced;
    assign rise_o   = w_synced & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/dpwm_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dpwm_decoder
// Purpose  : Recovers the duty count of a DPWM waveform; optional glitch
//            filter enabled by DPWM_DECODER_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dpwm_decoder
    import dpwm_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int REF_W  = REF_W_DEF
) (
    input  logic             f_in,
    input  logic             Reset,
    input  logic             Signal_i,
    output logic [REF_W-1:0] Ref_o,
    output logic             Valid_o,
    output logic             Err_o
);

    localparam int              CNT_W = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0] PER_C = CNT_W'(PERIOD);

    logic w_synced;
    logic w_rise;

    dpwm_sync u_sync (
        .f_in     (f_in),
        .Reset    (Reset),
        .signal_i (Signal_i),
        .synced_o (w_synced),
        .rise_o   (w_rise)
    );

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q,  hi_cnt_d;
    logic [REF_W-1:0] ref_q,     ref_d;
    logic             valid_q,   valid_d;
    logic             err_q,     err_d;
    logic [CNT_W-1:0] w_elapsed;
    logic             w_boundary;

    // Cycles since the last boundary, counting the current one; a full
    // period therefore reads PERIOD on the cycle the next rise is due.
    always_comb begin
        w_elapsed = (per_cnt_q >= PER_C) ? PER_C : per_cnt_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        w_boundary = 1'b0;

        if (w_rise) begin
            w_boundary = 1'b1;
            if (state_q == WAIT) begin
                state_d = LOCK;
            end else if (w_elapsed == PER_C) begin
                ref_d   = REF_W'(hi_cnt_q);
                valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (w_elapsed == PER_C) begin
            // No rise for a whole period: a flat level is a legal 0 % or
            // 100 % duty, anything else means a fall without a rise.
            w_boundary = 1'b1;
            if (hi_cnt_q == '0) begin
                ref_d   = '0;
                valid_d = 1'b1;
                state_d = LOCK;
            end else if (hi_cnt_q == PER_C) begin
                ref_d   = REF_W'(PERIOD);
                valid_d = 1'b1;
                state_d = LOCK;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (w_boundary) begin
            per_cnt_d = '0;
            hi_cnt_d  = {{(CNT_W-1){1'b0}}, w_synced};
        end else begin
            per_cnt_d = w_elapsed;
            hi_cnt_d  = (w_synced && (hi_cnt_q < PER_C)) ? hi_cnt_q + 1'b1 : hi_cnt_q;
        end
    end

    always_ff @(posedge f_in or posedge Reset) begin
        if (Reset) begin
            state_q   <= WAIT;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            ref_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            ref_q     <= ref_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign Ref_o   = ref_q;
    assign Valid_o = valid_q;
    assign Err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dpwm_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dpwm_decoder
// Purpose  : Scoreboard bench for dpwm_decoder against a period-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpwm_decoder;

    localparam int PERIOD = 10;
    localparam int REF_W  = 4;
`ifdef DPWM_DECODER_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic             f_in     = 1'b0;
    logic             Reset    = 1'b1;
    logic             Signal_i = 1'b0;
    logic [REF_W-1:0] Ref_o;
    logic             Valid_o;
    logic             Err_o;

    dpwm_decoder #(.PERIOD(PERIOD), .REF_W(REF_W)) dut (
        .f_in     (f_in),
        .Reset    (Reset),
        .Signal_i (Signal_i),
        .Ref_o    (Ref_o),
        .Valid_o  (Valid_o),
        .Err_o    (Err_o)
    );

    always #1000 f_in = ~f_in;

    int cyc = 0;
    always @(posedge f_in) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int refv;
        int at;
    } exp_t;

    exp_t q[$];
    bit   sig_hist [0:8191];
    int   rel      = 0;
    bit   locked   = 1'b0;
    int   bnd      = 0;
    int   last_ref = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    // Signal level as seen by the decoder: two cycles of synchronizer delay,
    // zero for anything sampled while Reset was held.
    function automatic bit raw_s(input int n);
        if (n - 2 >= rel) return sig_hist[n-2];
        return 1'b0;
    endfunction

    function automatic bit syn(input int n);
        int votes;
        if (!FILT) return raw_s(n);
        votes = int'(raw_s(n)) + int'(raw_s(n-1)) + int'(raw_s(n-2));
        return votes >= 2;
    endfunction

    // One decision per cycle; the decoder's response appears the next cycle.
    task automatic model_step(input int n);
        bit r;
        int el;
        int hi;
        r  = syn(n) && !syn(n-1);
        el = n - bnd;
        hi = 0;
        for (int k = bnd; k < n; k++) hi += int'(syn(k));
        if (r) begin
            if (!locked) locked = 1'b1;
            else if (el == PERIOD) begin
                last_ref = hi;
                q.push_back('{1'b0, hi, n + 1});
            end else q.push_back('{1'b1, last_ref, n + 1});
            bnd = n;
        end else if (el == PERIOD) begin
            if (hi == 0 || hi == PERIOD) begin
                last_ref = hi;
                locked   = 1'b1;
                q.push_back('{1'b0, hi, n + 1});
            end else q.push_back('{1'b1, last_ref, n + 1});
            bnd = n;
        end
    endtask

    task automatic tick(input bit s);
        @(posedge f_in);
        #1;
        Signal_i      = s;
        sig_hist[cyc] = s;
        model_step(cyc);
    endtask

    task automatic period(input int len, input int duty);
        for (int i = 0; i < len; i++) tick(i < duty);
    endtask

    task automatic do_reset(input int hold);
        @(posedge f_in);
        #1;
        Reset         = 1'b1;
        Signal_i      = 1'b0;
        sig_hist[cyc] = 1'b0;
        q.delete();
        #1;
        vectors++;
        if (Ref_o !== '0 || Valid_o !== 1'b0 || Err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ref=%0d valid=%0b err=%0b, expected all 0",
                     Ref_o, Valid_o, Err_o);
        end
        repeat (hold) begin
            @(posedge f_in);
            #1;
            sig_hist[cyc] = 1'b0;
        end
        @(posedge f_in);
        #1;
        Reset         = 1'b0;
        rel           = cyc;
        locked        = 1'b0;
        bnd           = cyc - 1;
        last_ref      = 0;
        sig_hist[cyc] = 1'b0;
        model_step(cyc);
    endtask

    always @(negedge f_in) begin
        exp_t e;
        if (!Reset) begin
            while (q.size() > 0 && q[0].at < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missed_pulse: got nothing, expected %s ref=%0d at cycle %0d",
                         q[0].is_err ? "err" : "valid", q[0].refv, q[0].at);
                void'(q.pop_front());
            end
            if (Valid_o && Err_o) begin
                vectors++;
                miscompares++;
                $display("FAIL exclusive: got valid=1 err=1 at cycle %0d, expected at most one", cyc);
            end
            if (Valid_o || Err_o) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse: got valid=%0b err=%0b ref=%0d at cycle %0d, expected no pulse",
                             Valid_o, Err_o, Ref_o, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.at != cyc || e.is_err != Err_o || int'(Ref_o) != e.refv) begin
                        miscompares++;
                        $display("FAIL pulse: got valid=%0b err=%0b ref=%0d at cycle %0d, expected %s ref=%0d at cycle %0d",
                                 Valid_o, Err_o, Ref_o, cyc, e.is_err ? "err" : "valid", e.refv, e.at);
                    end
                end
            end else if (q.size() > 0 && q[0].at == cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_pulse: got nothing at cycle %0d, expected %s ref=%0d",
                         cyc, q[0].is_err ? "err" : "valid", q[0].refv);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        do_reset(3);
        repeat (3) tick(1'b0);

        repeat (6) period(10, 9);
        repeat (2) period(10, 9);
        repeat (2) period(10, 1);
        repeat (2) period(10, 5);

        repeat (35) tick(1'b0);
        repeat (35) tick(1'b1);

        period(10, 9);
        period(6, 3);
        repeat (3) period(10, 9);

        repeat (4) tick(1'b1);
        do_reset(3);
        repeat (2) tick(1'b0);
        repeat (3) period(10, 7);

        repeat (3) begin
            repeat (4) tick(1'b1);
            repeat (2) tick(1'b0);
            tick(1'b1);
            repeat (3) tick(1'b0);
        end
        repeat (2) period(10, 4);

        repeat (40) begin
            int len;
            if ($urandom_range(0, 7) == 0) len = int'($urandom_range(2, 14));
            else                            len = PERIOD;
            period(len, int'($urandom_range(0, len)));
        end

        repeat (25) tick(1'b0);
        repeat (2) @(negedge f_in);

        while (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover: got nothing, expected %s ref=%0d at cycle %0d",
                     q[0].is_err ? "err" : "valid", q[0].refv, q[0].at);
            void'(q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
